// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Program counter plus a single-outstanding instruction fetch engine. After
//   reset the unit requests the word at PC, latches it into the instruction
//   register on the memory ack, then holds it for CONTROL until PC_LdEn asks
//   for the next (sequential or branch) instruction.
//
// Parameters
//   RESET_PC     value loaded into PC on reset
//
// Ports
//   Clk          clock, all state changes on the rising edge
//   Reset        synchronous active-high reset
//   PC_LdEn      advance PC and start the next fetch (only honoured in HOLD)
//   PC_sel       0 = PC+4, 1 = PC+4+(PC_Immed<<2)
//   PC_Immed     sign-extended branch offset in words
//   IMEM_addr    instruction memory byte address (= PC)
//   IMEM_req     registered fetch request
//   IMEM_ack     memory ack, IMEM_data valid in the same cycle
//   IMEM_data    instruction word from memory
//   Instr        instruction register
//   Instr_valid  Instr holds the instruction at the current PC
//   PC           current program counter
//   Fetch_err    sticky fetch-timeout flag
//
// Configuration
//   FETCH_TIMEOUT_EN  when defined, 16 consecutive ack-less request cycles
//                     park the unit in ERR with Fetch_err set until Reset.
//                     When undefined the request waits indefinitely and
//                     Fetch_err is tied low.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_LdEn,
  input  logic        PC_sel,
  input  logic [31:0] PC_Immed,
  output logic [31:0] IMEM_addr,
  output logic        IMEM_req,
  input  logic        IMEM_ack,
  input  logic [31:0] IMEM_data,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC,
  output logic        Fetch_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TO_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              req_q;
  logic              valid_q;

  logic [XLEN-1:0]   pc_seq_c;
  logic [XLEN-1:0]   offset_c;
  logic [XLEN-1:0]   pc_target_c;
  logic              timeout_c;

  // Next-PC candidates; the word offset shift keeps only the low 32 bits.
  assign pc_seq_c    = pc_q + XLEN'(4);
  assign offset_c    = PC_Immed << 2;
  assign pc_target_c = pc_seq_c + offset_c;

`ifdef FETCH_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;

  // Counts ack-less REQ cycles; cleared on every transition into REQ.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == S_IDLE) || ((state_q == S_HOLD) && PC_LdEn)) begin
      to_cnt_d = '0;
    end else if ((state_q == S_REQ) && !IMEM_ack) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // A counter already at its maximum marks the 16th consecutive miss.
  assign timeout_c = (to_cnt_q == {TO_W{1'b1}});

  always_ff @(posedge Clk) begin
    if (Reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= (state_d == S_ERR);
    end
  end

  assign Fetch_err = err_q;
`else
  assign timeout_c = 1'b0;
  assign Fetch_err = 1'b0;
`endif

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (IMEM_ack) begin
          instr_d = IMEM_data;
          state_d = S_HOLD;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (PC_LdEn) begin
          pc_d    = PC_sel ? pc_target_c : pc_seq_c;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; request/valid flags follow the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= (state_d == S_REQ);
      valid_q <= (state_d == S_HOLD);
    end
  end

  assign PC          = pc_q;
  assign IMEM_addr   = pc_q;
  assign Instr       = instr_q;
  assign IMEM_req    = req_q;
  assign Instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PC_LdEn;
  logic        PC_sel;
  logic [31:0] PC_Immed;
  logic [31:0] IMEM_addr;
  logic        IMEM_req;
  logic        IMEM_ack;
  logic [31:0] IMEM_data;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic        Fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference: fetch outstanding / instruction held / dead.
  logic [31:0] m_pc, m_instr;
  bit          m_fresh, m_busy, m_valid, m_dead;
  int          m_miss;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC_LdEn    (PC_LdEn),
    .PC_sel     (PC_sel),
    .PC_Immed   (PC_Immed),
    .IMEM_addr  (IMEM_addr),
    .IMEM_req   (IMEM_req),
    .IMEM_ack   (IMEM_ack),
    .IMEM_data  (IMEM_data),
    .Instr      (Instr),
    .Instr_valid(Instr_valid),
    .PC         (PC),
    .Fetch_err  (Fetch_err)
  );

  typedef struct {
    logic        ack;
    logic        ld;
    logic        sel;
    logic [31:0] imm;
    logic [31:0] data;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_tick();
    if (Reset) begin
      m_pc = RST_PC; m_instr = 32'h0; m_fresh = 1'b1;
      m_busy = 1'b0; m_valid = 1'b0; m_dead = 1'b0; m_miss = 0;
    end else if (m_fresh) begin
      m_fresh = 1'b0; m_busy = 1'b1; m_miss = 0;
    end else if (m_busy) begin
      if (IMEM_ack) begin
        m_instr = IMEM_data; m_busy = 1'b0; m_valid = 1'b1;
      end else begin
        m_miss++;
        if (TO_EN && (m_miss == 16)) begin
          m_busy = 1'b0; m_dead = 1'b1;
        end
      end
    end else if (m_valid && PC_LdEn) begin
      m_pc = m_pc + 32'd4 + (PC_sel ? 32'(PC_Immed * 32'd4) : 32'd0);
      m_valid = 1'b0; m_busy = 1'b1; m_miss = 0;
    end
  endfunction

  task automatic step();
    @(posedge Clk);
    model_tick();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".req"},   32'(IMEM_req),    32'(m_busy));
    check({tag, ".valid"}, 32'(Instr_valid), 32'(m_valid));
    check({tag, ".err"},   32'(Fetch_err),   32'(m_dead));
    check({tag, ".pc"},    PC,               m_pc);
    check({tag, ".addr"},  IMEM_addr,        m_pc);
    check({tag, ".instr"}, Instr,            m_instr);
  endtask

  task automatic quiet();
    PC_LdEn = 1'b0; PC_sel = 1'b0; PC_Immed = 32'h0; IMEM_ack = 1'b0; IMEM_data = 32'h0;
  endtask

  logic [31:0] imm_v;

  initial begin
    // idle -> req -> hold, branches (+3, -1 self loop), sequential step
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0099, 1'b1, 1'b0, 32'h00, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8000_0033, 1'b0, 1'b1, 32'h00, 32'h8000_0033};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 32'h00, 32'h8000_0033};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h3,         32'h0,         1'b1, 1'b0, 32'h10, 32'h8000_0033};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0011, 1'b0, 1'b1, 32'h10, 32'h0000_0011};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h14, 32'h0000_0011};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h5,         32'h0,         1'b1, 1'b0, 32'h14, 32'h0000_0011};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0022, 1'b0, 1'b1, 32'h14, 32'h0000_0022};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h2,         32'h0,         1'b1, 1'b0, 32'h20, 32'h0000_0022};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0033, 1'b0, 1'b1, 32'h20, 32'h0000_0033};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h20, 32'h0000_0033};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 1'b0, 1'b1, 32'h20, 32'h0000_0044};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h3,         32'h0,         1'b1, 1'b0, 32'h30, 32'h0000_0044};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0055, 1'b0, 1'b1, 32'h30, 32'h0000_0055};

    quiet();
    Reset = 1'b1;
    step();
    step();
    check("rst.pc",    PC,                 RST_PC);
    check("rst.instr", Instr,              32'h0);
    check("rst.req",   32'(IMEM_req),      32'h0);
    check("rst.valid", 32'(Instr_valid),   32'h0);
    check("rst.err",   32'(Fetch_err),     32'h0);
    Reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      IMEM_ack = tbl[i].ack; PC_LdEn = tbl[i].ld; PC_sel = tbl[i].sel;
      PC_Immed = tbl[i].imm; IMEM_data = tbl[i].data;
      step();
      check($sformatf("vec%0d.req", i),   32'(IMEM_req),    32'(tbl[i].e_req));
      check($sformatf("vec%0d.valid", i), 32'(Instr_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d.pc", i),    PC,               tbl[i].e_pc);
      check($sformatf("vec%0d.addr", i),  IMEM_addr,        tbl[i].e_pc);
      check($sformatf("vec%0d.instr", i), Instr,            tbl[i].e_instr);
    end
    quiet();

    // Ack delayed: request high for 5 cycles, ack in the 5th
    PC_LdEn = 1'b1;
    step();
    PC_LdEn = 1'b0;
    check("dly.enter.req", 32'(IMEM_req), 32'h1);
    for (int k = 0; k < 4; k++) begin
      IMEM_data = $urandom;
      step();
      check($sformatf("dly%0d.req", k),   32'(IMEM_req),    32'h1);
      check($sformatf("dly%0d.valid", k), 32'(Instr_valid), 32'h0);
      check($sformatf("dly%0d.addr", k),  IMEM_addr,        32'h34);
      check($sformatf("dly%0d.instr", k), Instr,            32'h0000_0055);
    end
    IMEM_ack = 1'b1; IMEM_data = 32'h0000_CAFE;
    step();
    check("dly.cap.valid", 32'(Instr_valid), 32'h1);
    check("dly.cap.instr", Instr,            32'h0000_CAFE);
    for (int k = 0; k < 3; k++) begin
      IMEM_data = $urandom;
      step();
      check($sformatf("once%0d.instr", k), Instr,         32'h0000_CAFE);
      check($sformatf("once%0d.req", k),   32'(IMEM_req), 32'h0);
    end
    quiet();

    // Branch onto the last word, then wrap to zero, then offset top bits dropped
    imm_v = (32'hFFFF_FFFC - PC - 32'd4) >> 2;
    PC_LdEn = 1'b1; PC_sel = 1'b1; PC_Immed = imm_v;
    step();
    check("wrap.top", PC, 32'hFFFF_FFFC);
    quiet(); IMEM_ack = 1'b1; IMEM_data = 32'h1234_5678;
    step();
    quiet(); PC_LdEn = 1'b1;
    step();
    check("wrap.zero", PC, 32'h0);
    check_model("wrap");
    quiet(); IMEM_ack = 1'b1; IMEM_data = 32'h0000_0777;
    step();
    quiet(); PC_LdEn = 1'b1; PC_sel = 1'b1; PC_Immed = 32'hC000_0001;
    step();
    check("offs.trunc", PC, 32'h8);

    // Reset while a fetch is outstanding, ack in the same cycle discarded
    quiet(); Reset = 1'b1; IMEM_ack = 1'b1; IMEM_data = 32'hBEEF_0001;
    step();
    Reset = 1'b0; quiet();
    check("rreq.instr", Instr,            32'h0);
    check("rreq.req",   32'(IMEM_req),    32'h0);
    check("rreq.valid", 32'(Instr_valid), 32'h0);
    check("rreq.pc",    PC,               RST_PC);

    // No ack at all: timeout behaviour
    step();
    check("to.enter.req", 32'(IMEM_req), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_model($sformatf("to%0d", k));
      if (k == 15) begin
        check("to15.req", 32'(IMEM_req),  32'h1);
        check("to15.err", 32'(Fetch_err), 32'h0);
      end
    end
    check("to16.req", 32'(IMEM_req),  TO_EN ? 32'h0 : 32'h1);
    check("to16.err", 32'(Fetch_err), TO_EN ? 32'h1 : 32'h0);
    PC_LdEn = 1'b1; IMEM_ack = 1'b1; IMEM_data = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      if (TO_EN) IMEM_ack = 1'b0;
      step();
      check_model($sformatf("park%0d", k));
    end
    quiet(); Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("to.rst.err", 32'(Fetch_err), 32'h0);
    check("to.rst.req", 32'(IMEM_req),  32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      IMEM_ack  = ($urandom_range(0, 9) < 6);
      PC_LdEn   = 1'($urandom_range(0, 1));
      PC_sel    = 1'($urandom_range(0, 1));
      PC_Immed  = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : 32'($urandom_range(0, 31)) - 32'd16;
      IMEM_data = $urandom;
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
